data_mem: RTL and testbench

Parametrised, pipelined byte-addressable data memory for the core's load/store unit. Supports RISC-V LB/LH/LW/LBU/LHU and SB/SH/SW with sign or zero extension, as a valid/ready request port and a fixed-latency response port. Hardware zero-clear after reset, misalignment and range fault reporting, and an optional output register stage. Sits between the execute/memory stage and the bus, replacing the single-cycle data RAM.

---
 rtl/data_mem.sv | 192 +++++++++++++++++++
 tb/tb_data_mem.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// data_mem: byte-addressable data memory for the load/store unit.
// Accepts one load or store per cycle on a valid/ready request port and
// returns exactly one response per accepted request, in order, after a fixed
// latency (1 cycle, or 2 with OUT_REG=1). The array can be zero-filled by
// hardware after reset. Misaligned, out-of-range or illegal-width requests
// fault with no side effect.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// (and rst is low). req_ready depends only on internal state, never on
// req_valid. The response port has no backpressure: rsp_valid is a one-cycle
// pulse per accepted request, and rsp_rdata/rsp_fault hold between pulses.

module data_mem #(
    parameter int ADDR_WIDTH     = 12,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit OUT_REG        = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int CW    = ADDR_WIDTH - 2;
    localparam int WORDS = 2 ** CW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   clr_cnt;
    logic [31:0]     mem [WORDS];

    logic            accept;
    logic [CW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            req_bad;
    logic [3:0]      byte_en;
    logic [31:0]     wr_data;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     ld_data;

    logic            s1_valid;
    logic [31:0]     s1_rdata;
    logic            s1_fault;

    assign req_ready = (state == ST_RUN);
    assign accept    = req_valid & req_ready & ~rst;
    assign word_idx  = req_addr[ADDR_WIDTH-1:2];
    assign lane      = req_addr[1:0];

    // State register; reset picks CLEAR or RUN depending on CLEAR_ON_RESET.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET) state <= ST_CLEAR;
            else                state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Leave CLEAR once the last word has been zeroed.
    always_comb begin
        next_state = state;
        if (state == ST_CLEAR && (&clr_cnt)) next_state = ST_RUN;
    end

    // Clear word counter; wraps back to 0 as the clear completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Request decode: fault detection, byte enables, lane-replicated store data.
    always_comb begin
        req_bad = 1'b0;
        byte_en = 4'b0000;
        wr_data = req_wdata;
        if (|req_addr[31:ADDR_WIDTH]) req_bad = 1'b1;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) req_bad = 1'b1;
        if (req_store && req_funct3[2]) req_bad = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_bad = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wr_data = req_wdata;
            end
            default: begin
                byte_en = 4'b0000;
                wr_data = req_wdata;
            end
        endcase
    end

    // Load path: pick the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        rd_word = mem[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = rd_word[{req_addr[1], 4'b0000} +: 16];
        ld_data = '0;
        case (req_funct3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'h000000, rd_byte};
            3'b101:  ld_data = {16'h0000, rd_half};
            default: ld_data = '0;
        endcase
    end

    // Array write port: clear sweep in CLEAR, byte-enabled store in RUN.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept && req_store && !req_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // First response stage; data/fault hold their last values when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_rdata <= '0;
            s1_fault <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_fault <= req_bad;
                s1_rdata <= (req_bad || req_store) ? 32'h0 : ld_data;
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic        s2_valid;
            logic [31:0] s2_rdata;
            logic        s2_fault;

            // Optional second response stage for timing closure.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_rdata <= '0;
                    s2_fault <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_rdata <= s1_rdata;
                        s2_fault <= s1_fault;
                    end
                end
            end

            assign rsp_valid = s2_valid;
            assign rsp_rdata = s2_rdata;
            assign rsp_fault = s2_fault;
        end else begin : g_no_out_reg
            assign rsp_valid = s1_valid;
            assign rsp_rdata = s1_rdata;
            assign rsp_fault = s1_fault;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: two instances fed the same request stream, a small 64-byte
// array with latency 1 and a 4 KiB array with latency 2. Expected responses
// carry the cycle they are due in, so latency and contiguity are checked too.

module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy0, rv0, rf0;
    logic [31:0] rd0;
    logic        rdy1, rv1, rf1;
    logic [31:0] rd1;

    int cyc = 0;
    int n_checks = 0;
    int n_fails = 0;

    // {due cycle[64:33], fault[32], data[31:0]}
    logic [64:0] exp0_q[$];
    logic [64:0] exp1_q[$];

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] edata;
        logic        efault;
    } vec_t;
    vec_t vecs[$];

    data_mem #(.ADDR_WIDTH(6), .CLEAR_ON_RESET(1'b1), .OUT_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(rf0)
    );

    data_mem #(.ADDR_WIDTH(12), .CLEAR_ON_RESET(1'b1), .OUT_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_fault(rf1)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side of one DUT's response port
    task automatic mon(input int k, input logic v, input logic [31:0] d, input logic f);
        logic [64:0] e;
        int sz;
        sz = (k == 0) ? exp0_q.size() : exp1_q.size();
        e = '0;
        if (sz > 0) e = (k == 0) ? exp0_q[0] : exp1_q[0];
        if (v) begin
            if (sz == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL rsp%0d_unexpected: rsp_valid=1 with nothing outstanding (cycle %0d)", k, cyc);
            end else begin
                if (k == 0) void'(exp0_q.pop_front());
                else        void'(exp1_q.pop_front());
                chk($sformatf("rsp%0d_cycle", k), cyc, e[64:33]);
                chk($sformatf("rsp%0d_rdata", k), d, e[31:0]);
                chk($sformatf("rsp%0d_fault", k), {31'b0, f}, {31'b0, e[32]});
            end
        end else if (sz > 0 && int'(e[64:33]) <= cyc) begin
            chk($sformatf("rsp%0d_valid", k), {31'b0, v}, 32'd1);
            if (k == 0) void'(exp0_q.pop_front());
            else        void'(exp1_q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, rv0, rd0, rf0);
        mon(1, rv1, rd1, rf1);
    end

    // Driver: present one request for one cycle and queue its expected response
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ef);
        @(negedge clk);
        chk("req_ready0", {31'b0, rdy0}, 32'd1);
        chk("req_ready1", {31'b0, rdy1}, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        exp0_q.push_back({32'(cyc + 1), ef, ed});
        exp1_q.push_back({32'(cyc + 2), ef, ed});
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // One-cycle reset; anything still in flight is dropped
    task automatic do_reset();
        @(negedge clk);
        #1;
        exp0_q.delete();
        exp1_q.delete();
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready0", {31'b0, rdy0}, 32'd0);
        chk("rst_ready1", {31'b0, rdy1}, 32'd0);
        chk("rst_valid0", {31'b0, rv0}, 32'd0);
        chk("rst_valid1", {31'b0, rv1}, 32'd0);
        chk("rst_rdata0", rd0, 32'd0);
        chk("rst_rdata1", rd1, 32'd0);
        chk("rst_fault0", {31'b0, rf0}, 32'd0);
        chk("rst_fault1", {31'b0, rf1}, 32'd0);
        rst = 1'b0;
    endtask

    // Count cycles with req_ready low after reset release (bounded)
    task automatic measure_clear();
        int n0, n1, t;
        logic any_rv;
        n0 = 0; n1 = 0; t = 0; any_rv = 1'b0;
        while ((!rdy0 || !rdy1) && t < 3000) begin
            if (!rdy0) n0++;
            if (!rdy1) n1++;
            if (rv0 || rv1) any_rv = 1'b1;
            t++;
            @(negedge clk);
        end
        chk("clear_cycles0", n0, 32'd16);
        chk("clear_cycles1", n1, 32'd1024);
        chk("rsp_during_clear", {31'b0, any_rv}, 32'd0);
    endtask

    task automatic add(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ef);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.edata = ed; v.efault = ef;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] d;

        // Extension
        add(1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0,        0);
        add(0, 3'b000, 32'h11, 32'h0,        32'h0000007F, 0);
        add(0, 3'b000, 32'h12, 32'h0,        32'hFFFFFFFF, 0);
        add(0, 3'b100, 32'h12, 32'h0,        32'h000000FF, 0);
        add(0, 3'b001, 32'h12, 32'h0,        32'hFFFF80FF, 0);
        add(0, 3'b101, 32'h12, 32'h0,        32'h000080FF, 0);
        add(0, 3'b010, 32'h10, 32'h0,        32'h80FF7F01, 0);
        add(0, 3'b001, 32'h10, 32'h0,        32'h00007F01, 0);
        add(0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 0);
        // Partial stores
        add(1, 3'b010, 32'h20, 32'h11223344, 32'h0,        0);
        add(1, 3'b000, 32'h21, 32'hFFFFFFAA, 32'h0,        0);
        add(1, 3'b001, 32'h22, 32'h1234BEEF, 32'h0,        0);
        add(0, 3'b010, 32'h20, 32'h0,        32'hBEEFAA44, 0);
        add(0, 3'b000, 32'h23, 32'h0,        32'hFFFFFFBE, 0);
        add(0, 3'b101, 32'h20, 32'h0,        32'h0000AA44, 0);
        // Faults, each followed by an unchanged word 0
        add(1, 3'b010, 32'h00, 32'hCAFEF00D, 32'h0,        0);
        add(0, 3'b001, 32'h01, 32'h0,        32'h0,        1);
        add(0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 0);
        add(0, 3'b010, 32'h02, 32'h0,        32'h0,        1);
        add(0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 0);
        add(1, 3'b010, 32'h1000, 32'h0,      32'h0,        1);
        add(0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 0);
        add(0, 3'b011, 32'h00, 32'h0,        32'h0,        1);
        add(1, 3'b100, 32'h00, 32'hFFFFFFFF, 32'h0,        1);
        add(0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 0);
        add(1, 3'b001, 32'h01, 32'hFFFFFFFF, 32'h0,        1);
        add(1, 3'b010, 32'h02, 32'hFFFFFFFF, 32'h0,        1);
        add(0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 0);
        add(0, 3'b110, 32'h00, 32'h0,        32'h0,        1);
        add(0, 3'b111, 32'h00, 32'h0,        32'h0,        1);
        add(0, 3'b010, 32'h80000000, 32'h0,  32'h0,        1);
        add(0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 0);
        // Top byte of the small array
        add(1, 3'b000, 32'h3F, 32'h0000005A, 32'h0,        0);
        add(0, 3'b100, 32'h3F, 32'h0,        32'h0000005A, 0);
        add(0, 3'b010, 32'h3C, 32'h0,        32'h5A000000, 0);
        add(0, 3'b101, 32'h3E, 32'h0,        32'h00005A00, 0);
        add(0, 3'b010, 32'h10, 32'h0,        32'h80FF7F01, 0);

        // Power-on reset and first clear
        do_reset();
        measure_clear();

        // Preload a nonzero pattern, reset, and expect an all-zero array
        for (int i = 0; i < 16; i++) send(1, 3'b010, 32'(i * 4), 32'hA5A50000 | 32'(i + 1), 32'h0, 0);
        idle();
        repeat (3) idle();
        do_reset();
        measure_clear();
        for (int i = 0; i < 16; i++) send(0, 3'b010, 32'(i * 4), 32'h0, 32'h0, 0);
        repeat (3) idle();

        // Table vectors, back to back
        foreach (vecs[i]) send(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].edata, vecs[i].efault);
        repeat (3) idle();
        chk("hold_valid0", {31'b0, rv0}, 32'd0);
        chk("hold_valid1", {31'b0, rv1}, 32'd0);
        chk("hold_rdata0", rd0, 32'h80FF7F01);
        chk("hold_rdata1", rd1, 32'h80FF7F01);

        // Throughput: alternating SW/LW to one address
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            send(1, 3'b010, 32'h30, d, 32'h0, 0);
            send(0, 3'b010, 32'h30, 32'h0, d, 0);
        end
        repeat (4) idle();

        // Reset with requests in flight
        send(0, 3'b010, 32'h10, 32'h0, 32'h80FF7F01, 0);
        send(0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 0);
        do_reset();
        measure_clear();

        // Reset in the middle of a clear restarts it
        do_reset();
        repeat (5) @(negedge clk);
        do_reset();
        measure_clear();
        send(0, 3'b010, 32'h10, 32'h0, 32'h0, 0);
        repeat (4) idle();

        chk("outstanding0", exp0_q.size(), 32'd0);
        chk("outstanding1", exp1_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
